etapa_fetch: RTL and testbench
==============================

Name: etapa_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the control unit.
- Holds the PC and requests instructions from instruction memory over a REQ/ACK handshake.
- Latches each returned word and presents it, with opcode, funct3, funct7 and register fields split out, to the control unit and register file.
- Computes the next PC from the control unit's PC_SRC/JALR outputs once execution finishes, and traps on fetch timeout or misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ACK_TIMEOUT, 15, max cycles in REQ without IMEM_ACK before trap (1..255)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
IMEM_ADDR  out  32  fetch address, always equals PC
IMEM_REQ  out  1  fetch request, level; high only in state REQ
IMEM_ACK  in  1  memory ack; IMEM_DATA valid in the same cycle
IMEM_DATA  in  32  instruction word from memory
INSTR  out  32  latched instruction register
opcode  out  7  INSTR[6:0]
funct3  out  3  INSTR[14:12]
funct7  out  1  INSTR[30]
rd  out  5  INSTR[11:7]
rs1  out  5  INSTR[19:15]
rs2  out  5  INSTR[24:20]
INSTR_VALID  out  1  high in ISSUE; decoded fields valid
EXEC_DONE  in  1  current instruction has finished executing; PC may advance
PC_SRC  in  1  from control unit: take PC-relative branch/jump
JALR  in  1  from control unit: register-indirect jump
IMM  in  32  sign-extended immediate from immediate generator
RS1_VAL  in  32  register-file read of rs1
PC  out  32  current PC
PC_PLUS4  out  32  PC+4 (return address for JAL/JALR writeback)
TRAP  out  1  high in FAULT
TRAP_CAUSE  out  2  00 none, 01 fetch timeout, 10 misaligned target

Behaviour:
- Reset (async, immediate):
  - State REQ; PC = RESET_PC; INSTR = 0; timeout counter = 0; TRAP_CAUSE = 00.
  - IMEM_REQ goes high on the first clock edge after RST falls. While RST is high, IMEM_REQ = 0, INSTR_VALID = 0, TRAP = 0.
  - Reset mid-transaction abandons it; any ACK during reset is ignored.
- Moore FSM, states REQ, ISSUE, FAULT. All outputs derive from registered state and registers only.
- REQ:
  - IMEM_REQ = 1, IMEM_ADDR = PC.
  - On an edge with IMEM_ACK = 1: INSTR <= IMEM_DATA, counter <= 0, go ISSUE.
  - Otherwise counter increments. When counter == ACK_TIMEOUT-1 with no ACK: go FAULT, TRAP_CAUSE <= 01.
  - An ACK on the same edge as the timeout wins; no trap.
- ISSUE:
  - INSTR_VALID = 1, IMEM_REQ = 0. IMEM_ACK is ignored.
  - Wait for EXEC_DONE. On an edge with EXEC_DONE = 1, compute next:
    - JALR = 1: (RS1_VAL + IMM) & ~32'h1. JALR has priority over PC_SRC.
    - else PC_SRC = 1: PC + IMM.
    - else: PC + 4.
  - All additions are modulo 2^32; 32'hFFFF_FFFC + 4 = 0, no trap.
  - If next[1] == 1: go FAULT, TRAP_CAUSE <= 10, PC unchanged. Otherwise PC <= next, go REQ.
- FAULT:
  - TRAP = 1; IMEM_REQ = 0; INSTR_VALID = 0.
  - PC and INSTR hold the faulting values.
  - Terminal until RST.
- Decoded fields are always slices of INSTR; they are stable from ISSUE until the next ACK.
- PC_PLUS4 = PC + 4 combinationally, valid in every state.
- Throughput: minimum 2 cycles per instruction (ACK in the first REQ cycle, EXEC_DONE in the first ISSUE cycle).

Test Plan:
1. Reset with RESET_PC = 0, then ACK in the first REQ cycle with IMEM_DATA = 32'h002081B3 (ADD x3,x1,x2) -> next cycle INSTR_VALID = 1, opcode = 0110011, funct3 = 000, funct7 = 0, rd = 3, rs1 = 1, rs2 = 2. EXEC_DONE = 1 with PC_SRC = 0, JALR = 0 -> PC = 4 and IMEM_REQ = 1 on the following cycle.
2. At PC = 8, IMEM_DATA = 32'h40208233 (SUB), EXEC_DONE = 1, PC_SRC = 1, IMM = 32'hFFFFFFF8 -> funct7 = 1; PC becomes 0. Repeat with JALR = 1, PC_SRC = 1, RS1_VAL = 32'h101, IMM = 32'h0F -> PC = 32'h110 (JALR priority, bit 0 cleared).
3. ACK withheld with ACK_TIMEOUT = 15 -> TRAP = 1, TRAP_CAUSE = 01 after 15 REQ cycles, IMEM_REQ = 0. Variant with ACK on the 15th cycle -> no trap, INSTR latched.
4. JALR = 1, RS1_VAL = 32'h102, IMM = 0 -> TRAP_CAUSE = 10 and PC unchanged. Then RST = 1 -> PC = RESET_PC, TRAP = 0 immediately, without waiting for a clock edge.
5. PC = 32'hFFFFFFFC, sequential advance -> PC = 0, no trap. IMEM_ACK pulsed during ISSUE -> INSTR unchanged.
6. RST asserted mid-REQ, then ACK while RST is high -> INSTR = 0, INSTR_VALID stays 0. After RST falls, IMEM_REQ = 1 at RESET_PC.

Source files
------------

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a REQ/ACK handshake, latches and
// splits the instruction word, and computes the next PC once the current one has executed.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_REQ   | IMEM_REQ high, waiting for IMEM_ACK; timeout counter runs
//   S_ISSUE | INSTR valid to control unit, waiting for EXEC_DONE
//   S_FAULT | trap latched (fetch timeout or misaligned target), held until RST
module etapa_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INSTR,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        INSTR_VALID,
    input  logic        EXEC_DONE,
    input  logic        PC_SRC,
    input  logic        JALR,
    input  logic [31:0] IMM,
    input  logic [31:0] RS1_VAL,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        TRAP,
    output logic [1:0]  TRAP_CAUSE
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_ISSUE = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST    = 8'(ACK_TIMEOUT - 1);
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_TMO   = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        started_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;

    // started_q keeps the request low for the first cycle after reset release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            cnt_q     <= 8'h0;
            cause_q   <= CAUSE_NONE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        if (JALR) begin
            target = (RS1_VAL + IMM) & ~32'h1;
        end else if (PC_SRC) begin
            target = pc_q + IMM;
        end else begin
            target = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            S_REQ: begin
                if (started_q) begin
                    if (IMEM_ACK) begin
                        instr_d = IMEM_DATA;
                        cnt_d   = 8'h0;
                        state_d = S_ISSUE;
                    end else if (cnt_q == CNT_LAST) begin
                        cause_d = CAUSE_TMO;
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (EXEC_DONE) begin
                    if (target[1]) begin
                        cause_d = CAUSE_ALIGN;
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign IMEM_ADDR   = pc_q;
    assign IMEM_REQ    = (state_q == S_REQ) && started_q;
    assign INSTR_VALID = (state_q == S_ISSUE);
    assign TRAP        = (state_q == S_FAULT);
    assign TRAP_CAUSE  = cause_q;
    assign PC          = pc_q;
    assign PC_PLUS4    = pc_plus4;
    assign INSTR       = instr_q;
    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];
    assign rd          = instr_q[11:7];
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: a table of fetch/execute vectors with hand-computed results,
// plus directed sequences for timeout, async reset, PC wrap and ignored ACKs.
module tb_etapa_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic [31:0] INSTR;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        INSTR_VALID;
    logic        EXEC_DONE;
    logic        PC_SRC;
    logic        JALR;
    logic [31:0] IMM;
    logic [31:0] RS1_VAL;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        TRAP;
    logic [1:0]  TRAP_CAUSE;

    int checks   = 0;
    int failures = 0;

    etapa_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .INSTR(INSTR), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .INSTR_VALID(INSTR_VALID),
        .EXEC_DONE(EXEC_DONE), .PC_SRC(PC_SRC), .JALR(JALR), .IMM(IMM), .RS1_VAL(RS1_VAL),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .TRAP(TRAP), .TRAP_CAUSE(TRAP_CAUSE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        pc_src;
        logic        jalr;
        logic [31:0] imm;
        logic [31:0] rs1v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_pc;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [31:0] data, input logic pc_src, input logic jalr,
                                input logic [31:0] imm, input logic [31:0] rs1v,
                                input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] exp_pc, input logic [1:0] cause);
        vec_t v;
        v.data = data; v.pc_src = pc_src; v.jalr = jalr; v.imm = imm; v.rs1v = rs1v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rdv; v.rs1 = r1; v.rs2 = r2;
        v.exp_pc = exp_pc; v.cause = cause;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (IMEM_REQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, 32'(IMEM_REQ), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cur;
        int n;

        RST = 1'b1; IMEM_ACK = 1'b0; IMEM_DATA = 32'h0; EXEC_DONE = 1'b0;
        PC_SRC = 1'b0; JALR = 1'b0; IMM = 32'h0; RS1_VAL = 32'h0;

        //            data          src  jalr imm           rs1v         op       f3    f7   rd  rs1 rs2 exp_pc        cause
        vecs[0] = mk(32'h002081B3, 1'b0, 1'b0, 32'h0,        32'h0,   7'h33, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  32'h4,    2'b00);
        vecs[1] = mk(32'h00000013, 1'b0, 1'b0, 32'h0,        32'h0,   7'h13, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h8,    2'b00);
        vecs[2] = mk(32'h40208233, 1'b1, 1'b0, 32'hFFFFFFF8, 32'h0,   7'h33, 3'd0, 1'b1, 5'd4,  5'd1,  5'd2,  32'h0,    2'b00);
        vecs[3] = mk(32'h00F08067, 1'b1, 1'b1, 32'h0000000F, 32'h101, 7'h67, 3'd0, 1'b0, 5'd0,  5'd1,  5'd15, 32'h110,  2'b00);
        vecs[4] = mk(32'hFEDCBA98, 1'b1, 1'b0, 32'h00000FF0, 32'h0,   7'h18, 3'd3, 1'b1, 5'd21, 5'd25, 5'd13, 32'h1100, 2'b00);
        vecs[5] = mk(32'h00010067, 1'b0, 1'b1, 32'h0,        32'h102, 7'h67, 3'd0, 1'b0, 5'd0,  5'd2,  5'd0,  32'h1100, 2'b10);

        repeat (2) step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_req", 32'(IMEM_REQ), 32'd0);
        chk("rst_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_trap", 32'(TRAP), 32'd0);
        chk("rst_cause", 32'(TRAP_CAUSE), 32'd0);
        RST = 1'b0;
        chk("post_rst_req_low", 32'(IMEM_REQ), 32'd0);
        step();
        chk("first_edge_req", 32'(IMEM_REQ), 32'd1);

        exp_cur = 32'h0;
        for (int i = 0; i < 6; i++) begin
            wait_req($sformatf("v%0d_req", i));
            chk($sformatf("v%0d_addr", i), IMEM_ADDR, exp_cur);
            IMEM_ACK = 1'b1; IMEM_DATA = vecs[i].data;
            step();
            IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
            chk($sformatf("v%0d_valid", i), 32'(INSTR_VALID), 32'd1);
            chk($sformatf("v%0d_instr", i), INSTR, vecs[i].data);
            chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
            chk($sformatf("v%0d_funct3", i), 32'(funct3), 32'(vecs[i].f3));
            chk($sformatf("v%0d_funct7", i), 32'(funct7), 32'(vecs[i].f7));
            chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i), 32'(rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(rs2), 32'(vecs[i].rs2));
            EXEC_DONE = 1'b1; PC_SRC = vecs[i].pc_src; JALR = vecs[i].jalr;
            IMM = vecs[i].imm; RS1_VAL = vecs[i].rs1v;
            step();
            EXEC_DONE = 1'b0; PC_SRC = 1'b0; JALR = 1'b0; IMM = 32'h0; RS1_VAL = 32'h0;
            chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
            chk($sformatf("v%0d_pc4", i), PC_PLUS4, vecs[i].exp_pc + 32'd4);
            chk($sformatf("v%0d_cause", i), 32'(TRAP_CAUSE), 32'(vecs[i].cause));
            if (vecs[i].cause == 2'b00) begin
                chk($sformatf("v%0d_next_req", i), 32'(IMEM_REQ), 32'd1);
                exp_cur = vecs[i].exp_pc;
            end else begin
                chk($sformatf("v%0d_trap", i), 32'(TRAP), 32'd1);
                chk($sformatf("v%0d_trap_req", i), 32'(IMEM_REQ), 32'd0);
            end
        end

        // fault is terminal and holds PC/INSTR
        IMEM_ACK = 1'b1;
        repeat (3) step();
        IMEM_ACK = 1'b0;
        chk("fault_hold_trap", 32'(TRAP), 32'd1);
        chk("fault_hold_pc", PC, 32'h1100);
        chk("fault_hold_instr", INSTR, 32'h00010067);
        chk("fault_hold_valid", 32'(INSTR_VALID), 32'd0);

        #2 RST = 1'b1;
        #1;
        chk("async_rst_pc", PC, 32'h0);
        chk("async_rst_trap", 32'(TRAP), 32'd0);
        chk("async_rst_cause", 32'(TRAP_CAUSE), 32'd0);
        step();
        RST = 1'b0;

        // timeout: 15 REQ cycles without ACK
        wait_req("tmo_req");
        n = 0;
        while (IMEM_REQ === 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd15);
        chk("tmo_trap", 32'(TRAP), 32'd1);
        chk("tmo_cause", 32'(TRAP_CAUSE), 32'd1);
        chk("tmo_req_low", 32'(IMEM_REQ), 32'd0);

        // ACK on the 15th REQ cycle wins over the timeout
        RST = 1'b1;
        #1;
        step();
        RST = 1'b0;
        wait_req("late_ack_req");
        repeat (14) step();
        chk("late_ack_still_req", 32'(IMEM_REQ), 32'd1);
        chk("late_ack_no_trap_yet", 32'(TRAP), 32'd0);
        IMEM_ACK = 1'b1; IMEM_DATA = 32'h00A00093;
        step();
        IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
        chk("late_ack_valid", 32'(INSTR_VALID), 32'd1);
        chk("late_ack_instr", INSTR, 32'h00A00093);
        chk("late_ack_trap", 32'(TRAP), 32'd0);
        chk("late_ack_cause", 32'(TRAP_CAUSE), 32'd0);

        // PC wrap at the top of the address space
        EXEC_DONE = 1'b1; PC_SRC = 1'b1; IMM = 32'hFFFFFFFC;
        step();
        EXEC_DONE = 1'b0; PC_SRC = 1'b0; IMM = 32'h0;
        chk("wrap_pc", PC, 32'hFFFFFFFC);
        chk("wrap_addr", IMEM_ADDR, 32'hFFFFFFFC);
        chk("wrap_pc4", PC_PLUS4, 32'h0);
        IMEM_ACK = 1'b1; IMEM_DATA = 32'h00000013;
        step();
        IMEM_DATA = 32'hDEADBEEF;
        step();
        IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
        chk("issue_ack_ignored", INSTR, 32'h00000013);
        chk("issue_ack_valid", 32'(INSTR_VALID), 32'd1);
        EXEC_DONE = 1'b1;
        step();
        EXEC_DONE = 1'b0;
        chk("wrap_next_pc", PC, 32'h0);
        chk("wrap_no_trap", 32'(TRAP), 32'd0);
        chk("wrap_req", 32'(IMEM_REQ), 32'd1);

        // reset mid-REQ with ACK during reset
        step();
        RST = 1'b1;
        #1;
        chk("midreq_rst_instr", INSTR, 32'h0);
        IMEM_ACK = 1'b1; IMEM_DATA = 32'hCAFEF00D;
        step();
        step();
        chk("rst_ack_instr", INSTR, 32'h0);
        chk("rst_ack_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_ack_req", 32'(IMEM_REQ), 32'd0);
        RST = 1'b0; IMEM_ACK = 1'b0; IMEM_DATA = 32'h0;
        chk("rel_req_low", 32'(IMEM_REQ), 32'd0);
        step();
        chk("rel_req_high", 32'(IMEM_REQ), 32'd1);
        chk("rel_addr", IMEM_ADDR, 32'h0);
        chk("rel_valid", 32'(INSTR_VALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
